// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch unit with a credit-limited prefetch FIFO
//               of {instruction, PC} pairs and redirect/flush support.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int IW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic [IW-1:0] o_pc_addr,
    output logic          o_pc_rd,
    output logic [3:0]    o_pc_byte_en,
    input  logic [IW-1:0] i_pc_rddata,
    input  logic          i_redirect,
    input  logic [IW-1:0] i_redirect_pc,
    output logic          o_inst_valid,
    output logic [IW-1:0] o_inst,
    output logic [IW-1:0] o_inst_pc,
    input  logic          i_inst_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_RUN   = 1'b1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [0:0]      r_state;
    logic [IW-1:0]   r_fetch_pc;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_inflight;
    logic [IW-1:0]   r_inflight_pc;
    logic            r_drop;

    logic [IW-1:0]   r_fifo_inst [DEPTH];
    logic [IW-1:0]   r_fifo_pc   [DEPTH];

    logic [CW-1:0]   w_used;
    logic            w_credit;
    logic            w_rd;
    logic            w_push;
    logic            w_pop;
    logic            w_unused_pc_lsb;

    // Slots already claimed include the response still on its way back.
    assign w_used   = r_count + {{AW{1'b0}}, r_inflight};
    assign w_credit = (w_used < c_depth);
    assign w_rd     = (r_state == S_RUN) && w_credit && !i_redirect;

    // A response coinciding with a redirect belongs to the old stream.
    assign w_push   = r_inflight && !r_drop && !i_redirect;
    assign w_pop    = o_inst_valid && i_inst_ready && !i_redirect;

    assign o_pc_rd      = w_rd;
    assign o_pc_addr    = r_fetch_pc;
    assign o_pc_byte_en = 4'b1111;
    assign o_inst_valid = (r_count != '0);
    assign o_inst       = r_fifo_inst[r_rd_ptr];
    assign o_inst_pc    = r_fifo_pc[r_rd_ptr];

    assign w_unused_pc_lsb = ^i_redirect_pc[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_RUN;
                S_RUN:   r_state <= S_RUN;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_drop        <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            r_drop     <= i_redirect && r_inflight;
            if (w_rd) begin
                r_inflight_pc <= r_fetch_pc;
            end
            if (i_redirect) begin
                r_fetch_pc <= {i_redirect_pc[IW-1:2], 2'b00};
            end else if (w_rd) begin
                r_fetch_pc <= r_fetch_pc + IW'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= i_pc_rddata;
            r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push && !w_pop) begin
            assert (r_count != c_depth);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue with a queue-based model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int IW    = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic [IW-1:0] o_pc_addr;
    logic          o_pc_rd;
    logic [3:0]    o_pc_byte_en;
    logic [IW-1:0] i_pc_rddata;
    logic          i_redirect;
    logic [IW-1:0] i_redirect_pc;
    logic          o_inst_valid;
    logic [IW-1:0] o_inst;
    logic [IW-1:0] o_inst_pc;
    logic          i_inst_ready;

    fetch_queue #(.IW(IW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .o_pc_addr     (o_pc_addr),
        .o_pc_rd       (o_pc_rd),
        .o_pc_byte_en  (o_pc_byte_en),
        .i_pc_rddata   (i_pc_rddata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_inst_valid  (o_inst_valid),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .i_inst_ready  (i_inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [IW-1:0] pc;
    } ent_t;

    // Reference model: a plain queue of delivered words plus one pending read.
    ent_t          mq[$];
    logic [IW-1:0] m_fpc;
    logic [IW-1:0] m_pend_pc;
    bit            m_pend;
    bit            m_drop;
    bit            m_run;

    // Instruction memory: answers the DUT's read one cycle later with addr+0x100.
    bit            mem_v;
    logic [IW-1:0] mem_a;

    bit            e_rd;
    bit            e_valid;
    logic [IW-1:0] e_addr;
    logic [IW-1:0] e_inst;
    logic [IW-1:0] e_ipc;

    task automatic m_reset();
        mq.delete();
        m_fpc  = '0;
        m_pend = 1'b0;
        m_pend_pc = '0;
        m_drop = 1'b0;
        m_run  = 1'b0;
        mem_v  = 1'b0;
        mem_a  = '0;
    endtask

    task automatic drive(input bit rdy, input bit redir, input logic [IW-1:0] rpc);
        i_inst_ready  = rdy;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_pc_rddata   = mem_v ? (mem_a + 32'h100) : $urandom;
        #1;
        e_rd    = m_run && ((mq.size() + int'(m_pend)) < DEPTH) && !redir;
        e_addr  = m_fpc;
        e_valid = (mq.size() != 0);
        e_inst  = e_valid ? mq[0].inst : '0;
        e_ipc   = e_valid ? mq[0].pc   : '0;
    endtask

    task automatic tick();
        bit push;
        bit pop;
        push = m_pend && !m_drop && !i_redirect;
        pop  = e_valid && i_inst_ready && !i_redirect;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{inst: i_pc_rddata, pc: m_pend_pc});
        if (i_redirect) begin
            mq.delete();
            m_fpc  = {i_redirect_pc[IW-1:2], 2'b00};
            m_drop = m_pend;
            m_pend = 1'b0;
        end else begin
            m_drop = 1'b0;
            m_pend = e_rd;
            if (e_rd) begin
                m_pend_pc = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end
        end
        m_run = 1'b1;
        mem_v = o_pc_rd;
        mem_a = o_pc_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_inst_ready = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_inst_ready = 1'b1;
        i_redirect = 1'b0;
        i_redirect_pc = 32'h1234;
        i_pc_rddata = $urandom;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (o_pc_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %0b want 0", o_pc_rd); end
        n_vec++; if (o_pc_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", o_pc_addr); end
        n_vec++; if (o_inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", o_inst_valid); end
        n_vec++; if (o_pc_byte_en !== 4'hF) begin n_err++; $display("FAIL byte_en: got %h want f", o_pc_byte_en); end
        @(negedge clk);
        reset = 1'b1;
        m_reset();
    endtask

    task automatic test_stream();
        do_reset();
        drive(1, 0, '0);
        n_vec++; if (o_pc_rd !== 1'b0) begin n_err++; $display("FAIL stream_idle_rd: got %0b want 0", o_pc_rd); end
        tick();
        drive(1, 0, '0);
        n_vec++; if (o_pc_rd !== 1'b1 || o_pc_addr !== 32'h0) begin n_err++; $display("FAIL stream_first_rd: got rd=%0b addr=%h want rd=1 addr=0", o_pc_rd, o_pc_addr); end
        n_vec++; if (o_inst_valid !== 1'b0) begin n_err++; $display("FAIL stream_early_valid: got %0b want 0", o_inst_valid); end
        tick();
        drive(1, 0, '0);
        n_vec++; if (o_inst_valid !== 1'b0) begin n_err++; $display("FAIL stream_resp_valid: got %0b want 0", o_inst_valid); end
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, '0);
            n_vec++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'(4 * k) || o_inst !== 32'(4 * k + 32'h100)) begin
                n_err++; $display("FAIL stream_out[%0d]: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                                  k, o_inst_valid, o_inst_pc, o_inst, 32'(4 * k), 32'(4 * k + 32'h100));
            end
            n_vec++; if (o_pc_rd !== 1'b1) begin n_err++; $display("FAIL stream_rd[%0d]: got %0b want 1", k, o_pc_rd); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] addrs [8];
        int n_rd;
        n_rd = 0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, '0);
            if (o_pc_rd === 1'b1 && n_rd < 8) begin
                addrs[n_rd] = o_pc_addr;
                n_rd++;
            end
            tick();
        end
        n_vec++; if (n_rd != 4) begin n_err++; $display("FAIL bp_read_count: got %0d want 4", n_rd); end
        for (int i = 0; i < 4 && i < n_rd; i++) begin
            n_vec++; if (addrs[i] !== 32'(4 * i)) begin n_err++; $display("FAIL bp_addr[%0d]: got %h want %h", i, addrs[i], 32'(4 * i)); end
        end
        drive(0, 0, '0);
        n_vec++; if (o_inst_valid !== 1'b1 || o_pc_rd !== 1'b0) begin n_err++; $display("FAIL bp_full: got v=%0b rd=%0b want v=1 rd=0", o_inst_valid, o_pc_rd); end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, '0);
            n_vec++; if (o_inst_pc !== 32'(4 * i) || o_inst !== 32'(4 * i + 32'h100)) begin
                n_err++; $display("FAIL bp_drain[%0d]: got pc=%h inst=%h want pc=%h inst=%h", i, o_inst_pc, o_inst, 32'(4 * i), 32'(4 * i + 32'h100));
            end
            if (i == 0) begin
                n_vec++; if (o_pc_rd !== 1'b0) begin n_err++; $display("FAIL bp_no_rd_full: got %0b want 0", o_pc_rd); end
            end
            if (i == 1) begin
                n_vec++; if (o_pc_rd !== 1'b1 || o_pc_addr !== 32'h10) begin n_err++; $display("FAIL bp_resume: got rd=%0b addr=%h want rd=1 addr=10", o_pc_rd, o_pc_addr); end
            end
            tick();
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        repeat (4) begin drive(1, 0, '0); tick(); end
        drive(1, 1, 32'h203);
        n_vec++; if (o_pc_rd !== 1'b0) begin n_err++; $display("FAIL redir_rd_blocked: got %0b want 0", o_pc_rd); end
        tick();
        drive(1, 0, '0);
        n_vec++; if (o_pc_rd !== 1'b1 || o_pc_addr !== 32'h200) begin n_err++; $display("FAIL redir_addr: got rd=%0b addr=%h want rd=1 addr=200", o_pc_rd, o_pc_addr); end
        n_vec++; if (o_inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %0b want 0", o_inst_valid); end
        tick();
        drive(1, 0, '0);
        n_vec++; if (o_inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_drop: got %0b want 0", o_inst_valid); end
        tick();
        drive(1, 0, '0);
        n_vec++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h200 || o_inst !== 32'h300) begin
            n_err++; $display("FAIL redir_first: got v=%0b pc=%h inst=%h want v=1 pc=200 inst=300", o_inst_valid, o_inst_pc, o_inst);
        end
        tick();
    endtask

    task automatic test_redirect_pop();
        do_reset();
        repeat (4) begin drive(0, 0, '0); tick(); end
        drive(1, 1, 32'h40);
        n_vec++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h0) begin n_err++; $display("FAIL rp_head: got v=%0b pc=%h want v=1 pc=0", o_inst_valid, o_inst_pc); end
        tick();
        drive(1, 0, '0);
        n_vec++; if (o_inst_valid !== 1'b0) begin n_err++; $display("FAIL rp_cleared: got %0b want 0", o_inst_valid); end
        n_vec++; if (o_pc_rd !== 1'b1 || o_pc_addr !== 32'h40) begin n_err++; $display("FAIL rp_addr: got rd=%0b addr=%h want rd=1 addr=40", o_pc_rd, o_pc_addr); end
        tick();
    endtask

    task automatic test_wrap();
        drive(1, 1, 32'hFFFF_FFFE);
        tick();
        drive(1, 0, '0);
        n_vec++; if (o_pc_rd !== 1'b1 || o_pc_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_top: got rd=%0b addr=%h want rd=1 addr=fffffffc", o_pc_rd, o_pc_addr); end
        tick();
        drive(1, 0, '0);
        n_vec++; if (o_pc_rd !== 1'b1 || o_pc_addr !== 32'h0) begin n_err++; $display("FAIL wrap_zero: got rd=%0b addr=%h want rd=1 addr=0", o_pc_rd, o_pc_addr); end
        tick();
        drive(1, 0, '0);
        n_vec++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'hFFFF_FFFC || o_inst !== 32'h0000_00FC) begin
            n_err++; $display("FAIL wrap_out: got v=%0b pc=%h inst=%h want v=1 pc=fffffffc inst=fc", o_inst_valid, o_inst_pc, o_inst);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        repeat (8) begin drive(0, 0, '0); tick(); end
        drive(1, 0, '0);
        tick();
        drive(0, 0, '0);
        n_vec++; if (o_inst_valid !== 1'b1 || o_pc_rd !== 1'b1) begin n_err++; $display("FAIL mr_pre: got v=%0b rd=%0b want v=1 rd=1", o_inst_valid, o_pc_rd); end
        #1 reset = 1'b0;
        #1;
        n_vec++; if (o_inst_valid !== 1'b0 || o_pc_rd !== 1'b0 || o_pc_addr !== 32'h0) begin
            n_err++; $display("FAIL mr_async: got v=%0b rd=%0b addr=%h want v=0 rd=0 addr=0", o_inst_valid, o_pc_rd, o_pc_addr);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        mem_v = 1'b1;
        mem_a = 32'h10;
        drive(1, 0, '0);
        n_vec++; if (o_pc_rd !== 1'b0 || o_inst_valid !== 1'b0) begin n_err++; $display("FAIL mr_idle: got rd=%0b v=%0b want rd=0 v=0", o_pc_rd, o_inst_valid); end
        tick();
        drive(1, 0, '0);
        n_vec++; if (o_pc_rd !== 1'b1 || o_pc_addr !== 32'h0 || o_inst_valid !== 1'b0) begin
            n_err++; $display("FAIL mr_restart: got rd=%0b addr=%h v=%0b want rd=1 addr=0 v=0", o_pc_rd, o_pc_addr, o_inst_valid);
        end
        tick();
        drive(1, 0, '0);
        n_vec++; if (o_inst_valid !== 1'b0) begin n_err++; $display("FAIL mr_stale: got %0b want 0", o_inst_valid); end
        tick();
        drive(1, 0, '0);
        n_vec++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h0 || o_inst !== 32'h100) begin
            n_err++; $display("FAIL mr_first: got v=%0b pc=%h inst=%h want v=1 pc=0 inst=100", o_inst_valid, o_inst_pc, o_inst);
        end
        tick();
    endtask

    task automatic test_random();
        bit rdy;
        bit rdr;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rdr = ($urandom_range(0, 29) == 0);
            drive(rdy, rdr, $urandom);
            n_vec++; if (o_pc_rd !== e_rd) begin n_err++; $display("FAIL rnd_rd[%0d]: got %0b want %0b", k, o_pc_rd, e_rd); end
            n_vec++; if (o_pc_addr !== e_addr) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h want %h", k, o_pc_addr, e_addr); end
            n_vec++; if (o_inst_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", k, o_inst_valid, e_valid); end
            if (e_valid) begin
                n_vec++; if (o_inst !== e_inst || o_inst_pc !== e_ipc) begin
                    n_err++; $display("FAIL rnd_head[%0d]: got inst=%h pc=%h want inst=%h pc=%h", k, o_inst, o_inst_pc, e_inst, e_ipc);
                end
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        i_inst_ready = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        i_pc_rddata = '0;
        m_reset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_pop();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter IW, default 32, instruction and address width.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, 2 to 16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 o_pc_addr  output  IW  instruction memory word address, equal to fetch PC.
REQ-006 o_pc_rd  output  1  instruction memory read strobe, one word per asserted cycle.
REQ-007 o_pc_byte_en  output  4  constant 4'b1111.
REQ-008 i_pc_rddata  input  IW  read data; valid exactly one cycle after the o_pc_rd cycle.
REQ-009 i_redirect  input  1  one-cycle pulse from the downstream core that flushes the queue and restarts fetch.
REQ-010 i_redirect_pc  input  IW  new fetch PC, sampled when i_redirect is 1.
REQ-011 o_inst_valid  output  1  head entry is valid.
REQ-012 o_inst  output  IW  head instruction word.
REQ-013 o_inst_pc  output  IW  PC of the head instruction.
REQ-014 i_inst_ready  input  1  downstream accepts the head entry when o_inst_valid is also 1.

Function
REQ-015 The block SHALL hold these registers: fetch PC, DEPTH-entry FIFO of {instruction, PC}, rd/wr pointers, count (0..DEPTH), one in-flight bit with in-flight PC, drop bit, and FSM state.
REQ-016 FSM states SHALL be S_IDLE and S_RUN; reset enters S_IDLE; S_IDLE goes to S_RUN unconditionally on the next edge; S_RUN stays in S_RUN.
REQ-017 o_pc_rd SHALL be 1 only in S_RUN, and only when count + in-flight < DEPTH and i_redirect is 0.
REQ-018 On each o_pc_rd cycle, the block SHALL set in-flight to 1, record the in-flight PC, and advance fetch PC by 4 (wrapping modulo 2^IW).
REQ-019 In the cycle after a read, i_pc_rddata and the in-flight PC SHALL be pushed at the write pointer, unless the drop bit is set.
REQ-020 A pop SHALL occur when o_inst_valid and i_inst_ready are both 1 and i_redirect is 0; the read pointer then advances modulo DEPTH.
REQ-021 o_inst_valid SHALL equal (count != 0); o_inst and o_inst_pc SHALL come from the head entry combinationally.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and move both pointers.
REQ-023 Because of the credit rule in REQ-017, count SHALL never exceed DEPTH; a push into a full queue is impossible by construction and is asserted against in simulation.
REQ-024 On i_redirect, the following SHALL happen on the next edge:
  - count, rd pointer and wr pointer are cleared;
  - fetch PC becomes {i_redirect_pc[IW-1:2], 2'b00};
  - if a read is in flight, the drop bit is set so its returning data is discarded;
  - no read is issued and no pop takes effect in the redirect cycle.
REQ-025 The drop bit SHALL clear when the discarded response cycle completes.
REQ-026 A redirect in the same cycle as a returning response SHALL discard that response.
REQ-027 Back-to-back redirects SHALL each take effect; the last one determines fetch PC.
REQ-028 Reads and pushes SHALL flow with zero bubbles: with i_inst_ready held at 1, one instruction per cycle is sustained after the initial latency.
REQ-029 Latency: from the first o_pc_rd after reset or redirect to o_inst_valid SHALL be 2 cycles (the response cycle, then the registered head).

Reset
REQ-030 While reset is 0, the block SHALL set: fetch PC = 0, count = 0, pointers = 0, in-flight = 0, drop = 0, state = S_IDLE.
REQ-031 During reset, outputs SHALL be: o_pc_rd = 0, o_pc_addr = 0, o_inst_valid = 0.
REQ-032 Reset asserted mid-operation SHALL abandon any in-flight read; data returning after reset release is ignored.
REQ-033 FIFO data storage need not be reset.

Verification
REQ-034 Release reset, ready = 1, memory returns addr+0x100:
  - first o_pc_rd at addr 0 in cycle 2;
  - o_inst = 0x100 with o_inst_pc = 0 two cycles later;
  - one instruction per cycle thereafter.
REQ-035 Hold ready = 0: exactly 4 reads are issued (addresses 0, 4, 8, 0xC), count = 4, o_pc_rd stays 0; raising ready drains entries in order 0, 4, 8, 0xC and reads resume at 0x10.
REQ-036 Pulse redirect to 0x203 while a read is in flight:
  - the in-flight response is dropped;
  - the next read address is 0x200;
  - the first valid output has o_inst_pc = 0x200.
REQ-037 Redirect in the same cycle as ready = 1 with count = 2: no pop occurs, and count = 0 on the next cycle.
REQ-038 Redirect with fetch PC = 0xFFFFFFFC: the read at 0xFFFFFFFC is followed by a read at 0x00000000 (wrap).
REQ-039 Assert reset mid-stream with count = 3: o_inst_valid drops immediately; after release, fetch restarts at 0 with S_IDLE lasting one cycle.
